// File: rtl/intr_pkg.sv
// Shared definitions for the machine-mode interrupt controller: register map,
// AXI response codes and the per-source gateway state encoding.
package intr_pkg;

  localparam logic [31:0] MSIP_OFF    = 32'h0000_0000;
  localparam logic [31:0] ENABLE_OFF  = 32'h0000_0004;
  localparam logic [31:0] PENDING_OFF = 32'h0000_0008;
  localparam logic [31:0] CLAIM_OFF   = 32'h0000_000C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ID_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    INSVC   = 2'd2
  } gw_state_e;

endpackage

// File: rtl/intr_gateway.sv
// Per-source interrupt gateway: 2-flop synchronizer plus IDLE/PENDING/INSVC FSM.
// Define INTR_EDGE_EN for edge-triggered sources with a deferred-edge flag.
module intr_gateway
  import intr_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic [1:0] sync_q;
  logic       level;
  logic       trig;
  gw_state_e  state_q, state_d;

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
    end else begin
      sync_q  <= {sync_q[0], src_i};
      state_q <= state_d;
    end
  end

  assign level = sync_q[1];

`ifdef INTR_EDGE_EN
  logic prev_q;
  logic defer_q, defer_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q  <= 1'b0;
      defer_q <= 1'b0;
    end else begin
      prev_q  <= level;
      defer_q <= defer_d;
    end
  end

  assign trig = level & ~prev_q;
`else
  assign trig = level;
`endif

  // NOTE: defaults are assigned first so no path leaves a next-state unassigned (no latch).
  always_comb begin
    state_d = state_q;
`ifdef INTR_EDGE_EN
    defer_d = defer_q;
`endif
    case (state_q)
      IDLE: begin
        if (trig) state_d = PENDING;
      end
      PENDING: begin
        if (claim_i) state_d = INSVC;
      end
      INSVC: begin
`ifdef INTR_EDGE_EN
        // An edge arriving while in service is remembered and replayed on complete.
        if (trig) defer_d = 1'b1;
        if (complete_i) begin
          state_d = (defer_q || trig) ? PENDING : IDLE;
          defer_d = 1'b0;
        end
`else
        if (complete_i) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_o = (state_q == PENDING);

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt aggregator with AXI4-Lite register interface.
// Build option INTR_EDGE_EN selects edge-triggered source gateways.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      axi_araddr,
  output logic             axi_arready,
  input  logic             axi_arvalid,
  input  logic [2:0]       axi_arprot,
  output logic [31:0]      axi_rdata,
  input  logic             axi_rready,
  output logic [1:0]       axi_rresp,
  output logic             axi_rvalid,
  input  logic             axi_bready,
  output logic [1:0]       axi_bresp,
  output logic             axi_bvalid,
  input  logic [31:0]      axi_awaddr,
  output logic             axi_awready,
  input  logic             axi_awvalid,
  input  logic [2:0]       axi_awprot,
  input  logic [31:0]      axi_wdata,
  output logic             axi_wready,
  input  logic [3:0]       axi_wstrb,
  input  logic             axi_wvalid,
  input  logic             time_intr,
  input  logic [N_SRC-1:0] ext_src,
  output logic             mtip,
  output logic             msip,
  output logic             meip
);

  logic             rvalid_q, bvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q, bresp_q;
  logic             msip_reg_q;
  logic [N_SRC-1:0] enable_q;
  logic             mtip_q, msip_q, meip_q;

  logic             rd_accept, wr_accept, wr_en;
  logic [31:0]      rd_data_d;
  logic [1:0]       rd_resp_d, wr_resp_d;
  logic             claim_hit, msip_we, enable_we, complete_we;
  logic [ID_W-1:0]  claim_id;
  logic [N_SRC-1:0] pending, pend_en, claim_vec, complete_vec;

  logic unused_ok;
  assign unused_ok = ^{axi_arprot, axi_awprot, axi_wdata, axi_wstrb};

  assign rd_accept = axi_arvalid & axi_arready;
  assign wr_accept = axi_awvalid & axi_wvalid & axi_awready;
  assign wr_en     = wr_accept & axi_wstrb[0];
  assign pend_en   = pending & enable_q;

  // Lowest index wins: scanning downward lets the smallest hit overwrite the rest.
  always_comb begin
    claim_id  = '0;
    claim_vec = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (pend_en[k]) begin
        claim_id     = ID_W'(k + 1);
        claim_vec    = '0;
        claim_vec[k] = 1'b1;
      end
    end
    if (!claim_hit) claim_vec = '0;
  end

  always_comb begin
    rd_data_d = '0;
    rd_resp_d = RESP_OKAY;
    claim_hit = 1'b0;
    case (axi_araddr)
      MSIP_OFF:    rd_data_d = {31'b0, msip_reg_q};
      ENABLE_OFF:  rd_data_d = 32'(enable_q);
      PENDING_OFF: rd_data_d = 32'(pending);
      CLAIM_OFF: begin
        rd_data_d = 32'(claim_id);
        claim_hit = rd_accept;
      end
      default:     rd_resp_d = RESP_SLVERR;
    endcase
  end

  always_comb begin
    wr_resp_d   = RESP_OKAY;
    msip_we     = 1'b0;
    enable_we   = 1'b0;
    complete_we = 1'b0;
    case (axi_awaddr)
      MSIP_OFF:    msip_we     = wr_en;
      ENABLE_OFF:  enable_we   = wr_en;
      PENDING_OFF: ;
      CLAIM_OFF:   complete_we = wr_en;
      default:     wr_resp_d   = RESP_SLVERR;
    endcase
  end

  always_comb begin
    complete_vec = '0;
    for (int k = 0; k < N_SRC; k++) begin
      complete_vec[k] = complete_we && (axi_wdata[ID_W-1:0] == ID_W'(k + 1));
    end
  end

  for (genvar k = 0; k < N_SRC; k++) begin : g_gw
    intr_gateway u_gw (
      .clk        (clk),
      .rstn       (rstn),
      .src_i      (ext_src[k]),
      .claim_i    (claim_vec[k]),
      .complete_i (complete_vec[k]),
      .pending_o  (pending[k])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      msip_reg_q <= 1'b0;
      enable_q   <= '0;
      mtip_q     <= 1'b0;
      msip_q     <= 1'b0;
      meip_q     <= 1'b0;
    end else begin
      if (rd_accept) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_d;
        rresp_q  <= rd_resp_d;
      end else if (rvalid_q && axi_rready) begin
        rvalid_q <= 1'b0;
      end

      if (wr_accept) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp_d;
      end else if (bvalid_q && axi_bready) begin
        bvalid_q <= 1'b0;
      end

      if (msip_we)   msip_reg_q <= axi_wdata[0];
      if (enable_we) enable_q   <= axi_wdata[N_SRC-1:0];

      mtip_q <= time_intr;
      msip_q <= msip_reg_q;
      meip_q <= |pend_en;
    end
  end

  assign axi_arready = ~rvalid_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_awready = ~bvalid_q;
  assign axi_wready  = ~bvalid_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign mtip        = mtip_q;
  assign msip        = msip_q;
  assign meip        = meip_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl; expectations follow INTR_EDGE_EN when defined.
module tb_intr_ctrl;

  localparam int N_SRC = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [31:0]      axi_araddr;
  logic             axi_arready;
  logic             axi_arvalid;
  logic [2:0]       axi_arprot;
  logic [31:0]      axi_rdata;
  logic             axi_rready;
  logic [1:0]       axi_rresp;
  logic             axi_rvalid;
  logic             axi_bready;
  logic [1:0]       axi_bresp;
  logic             axi_bvalid;
  logic [31:0]      axi_awaddr;
  logic             axi_awready;
  logic             axi_awvalid;
  logic [2:0]       axi_awprot;
  logic [31:0]      axi_wdata;
  logic             axi_wready;
  logic [3:0]       axi_wstrb;
  logic             axi_wvalid;
  logic             time_intr;
  logic [N_SRC-1:0] ext_src;
  logic             mtip, msip, meip;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic [1:0]  rr, br;
  logic        msip_at_b, meip_at_b;

  always #5 clk = ~clk;

  intr_ctrl #(.N_SRC(N_SRC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .axi_araddr  (axi_araddr),
    .axi_arready (axi_arready),
    .axi_arvalid (axi_arvalid),
    .axi_arprot  (axi_arprot),
    .axi_rdata   (axi_rdata),
    .axi_rready  (axi_rready),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_bready  (axi_bready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_awaddr  (axi_awaddr),
    .axi_awready (axi_awready),
    .axi_awvalid (axi_awvalid),
    .axi_awprot  (axi_awprot),
    .axi_wdata   (axi_wdata),
    .axi_wready  (axi_wready),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .time_intr   (time_intr),
    .ext_src     (ext_src),
    .mtip        (mtip),
    .msip        (msip),
    .meip        (meip)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    axi_rready  = 1'b1;
    while (!axi_arready && n < 20) begin
      step(1);
      n++;
    end
    check("arready_wait", {31'b0, axi_arready}, 32'h1);
    step(1);
    axi_arvalid = 1'b0;
    check("rvalid_after_ar", {31'b0, axi_rvalid}, 32'h1);
    data = axi_rdata;
    resp = axi_rresp;
    step(1);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n = 0;
    axi_awaddr  = addr;
    axi_wdata   = data;
    axi_wstrb   = strb;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    axi_bready  = 1'b1;
    while (!(axi_awready && axi_wready) && n < 20) begin
      step(1);
      n++;
    end
    check("awready_wait", {31'b0, axi_awready}, 32'h1);
    step(1);
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    check("bvalid_after_aw", {31'b0, axi_bvalid}, 32'h1);
    resp      = axi_bresp;
    msip_at_b = msip;
    meip_at_b = meip;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    axi_araddr  = '0;
    axi_arvalid = 1'b0;
    axi_arprot  = '0;
    axi_rready  = 1'b0;
    axi_bready  = 1'b0;
    axi_awaddr  = '0;
    axi_awvalid = 1'b0;
    axi_awprot  = '0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wvalid  = 1'b0;
    time_intr   = 1'b0;
    ext_src     = '0;
    step(3);

    check("rst_arready", {31'b0, axi_arready}, 32'h1);
    check("rst_awready", {31'b0, axi_awready}, 32'h1);
    check("rst_wready",  {31'b0, axi_wready},  32'h1);
    check("rst_rvalid",  {31'b0, axi_rvalid},  32'h0);
    check("rst_bvalid",  {31'b0, axi_bvalid},  32'h0);
    check("rst_irqs",    {29'b0, mtip, msip, meip}, 32'h0);
    rstn = 1'b1;
    step(1);

    axi_read(32'h8, rd, rr);
    check("pend_after_rst", rd, 32'h0);
    check("pend_rresp", {30'b0, rr}, 32'h0);
    axi_read(32'hC, rd, rr);
    check("claim_after_rst", rd, 32'h0);
    check("claim_rresp", {30'b0, rr}, 32'h0);

    // Software interrupt register and the one-cycle msip lag.
    axi_write(32'h0, 32'h1, 4'h1, br);
    check("msip_bresp", {30'b0, br}, 32'h0);
    check("msip_at_bvalid", {31'b0, msip_at_b}, 32'h0);
    check("msip_set", {31'b0, msip}, 32'h1);
    axi_read(32'h0, rd, rr);
    check("msip_readback", rd, 32'h1);
    axi_write(32'h0, 32'h0, 4'h1, br);
    check("msip_clr", {31'b0, msip}, 32'h0);
    axi_write(32'h0, 32'h1, 4'h0, br);
    axi_read(32'h0, rd, rr);
    check("msip_wstrb0_ignored", rd, 32'h0);

    // Disabled sources pend but do not raise meip.
    ext_src = 8'b0000_0110;
    step(4);
    axi_read(32'h8, rd, rr);
    check("pend_disabled", rd, 32'h6);
    check("meip_disabled", {31'b0, meip}, 32'h0);
    axi_write(32'h4, 32'hFFFF_FFFF, 4'h1, br);
    check("meip_at_enable_b", {31'b0, meip_at_b}, 32'h0);
    check("meip_enabled", {31'b0, meip}, 32'h1);
    axi_read(32'h4, rd, rr);
    check("enable_upper_zero", rd, 32'hFF);
    axi_read(32'hC, rd, rr);
    check("claim_first", rd, 32'h2);
    axi_read(32'hC, rd, rr);
    check("claim_second", rd, 32'h3);
    axi_read(32'hC, rd, rr);
    check("claim_empty", rd, 32'h0);
    check("meip_all_claimed", {31'b0, meip}, 32'h0);

    // Complete with the source still high.
    axi_write(32'hC, 32'h2, 4'h1, br);
    check("complete2_bresp", {30'b0, br}, 32'h0);
    axi_read(32'h8, rd, rr);
`ifdef INTR_EDGE_EN
    check("repend_level_high", rd, 32'h0);
    check("meip_after_repend", {31'b0, meip}, 32'h0);
`else
    check("repend_level_high", rd, 32'h2);
    check("meip_after_repend", {31'b0, meip}, 32'h1);
`endif

    ext_src = '0;
    step(4);
    axi_read(32'hC, rd, rr);
`ifdef INTR_EDGE_EN
    check("claim_after_drop", rd, 32'h0);
`else
    check("claim_after_drop", rd, 32'h2);
`endif
    axi_write(32'hC, 32'h2, 4'h1, br);
    axi_write(32'hC, 32'h3, 4'h1, br);
    axi_read(32'h8, rd, rr);
    check("pend_all_idle", rd, 32'h0);
    check("meip_all_idle", {31'b0, meip}, 32'h0);
    axi_write(32'hC, 32'h5, 4'h1, br);
    check("complete_idle_bresp", {30'b0, br}, 32'h0);
    axi_write(32'hC, 32'h1F, 4'h1, br);
    check("complete_oob_bresp", {30'b0, br}, 32'h0);
    axi_read(32'h8, rd, rr);
    check("pend_after_bogus_complete", rd, 32'h0);

    // Timer pass-through with one-cycle lag.
    time_intr = 1'b1;
    #1;
    check("mtip_lag_rise", {31'b0, mtip}, 32'h0);
    step(1);
    check("mtip_rise", {31'b0, mtip}, 32'h1);
    time_intr = 1'b0;
    #1;
    check("mtip_lag_fall", {31'b0, mtip}, 32'h1);
    step(1);
    check("mtip_fall", {31'b0, mtip}, 32'h0);

    // Unmapped addresses and read-only PENDING.
    axi_read(32'h10, rd, rr);
    check("unmapped_rresp", {30'b0, rr}, 32'h2);
    check("unmapped_rdata", rd, 32'h0);
    axi_write(32'h10, 32'h1, 4'h1, br);
    check("unmapped_bresp", {30'b0, br}, 32'h2);
    axi_write(32'h8, 32'hFF, 4'h1, br);
    check("pending_write_bresp", {30'b0, br}, 32'h0);

    // Read response back-pressure.
    axi_araddr  = 32'h4;
    axi_arvalid = 1'b1;
    axi_rready  = 1'b0;
    step(1);
    axi_arvalid = 1'b0;
    check("bp_rvalid", {31'b0, axi_rvalid}, 32'h1);
    check("bp_rdata", axi_rdata, 32'hFF);
    step(3);
    check("bp_arready_held", {31'b0, axi_arready}, 32'h0);
    check("bp_rvalid_held", {31'b0, axi_rvalid}, 32'h1);
    axi_rready = 1'b1;
    step(1);
    check("bp_rvalid_clear", {31'b0, axi_rvalid}, 32'h0);
    check("bp_arready_back", {31'b0, axi_arready}, 32'h1);

`ifdef INTR_EDGE_EN
    // Edge during service is deferred; steady level never re-triggers.
    ext_src = 8'b0000_0001;
    step(4);
    axi_read(32'hC, rd, rr);
    check("edge_claim1", rd, 32'h1);
    ext_src = '0;
    step(4);
    ext_src = 8'b0000_0001;
    step(4);
    axi_write(32'hC, 32'h1, 4'h1, br);
    axi_read(32'h8, rd, rr);
    check("edge_deferred_pend", rd, 32'h1);
    axi_read(32'hC, rd, rr);
    check("edge_claim1_again", rd, 32'h1);
    axi_write(32'hC, 32'h1, 4'h1, br);
    step(2);
    axi_read(32'h8, rd, rr);
    check("edge_no_repend", rd, 32'h0);
    ext_src = '0;
    step(4);
`endif

    // Reset asserted while a claim response is outstanding.
    ext_src = 8'b0000_0100;
    step(4);
    axi_araddr  = 32'hC;
    axi_arvalid = 1'b1;
    axi_rready  = 1'b0;
    step(1);
    axi_arvalid = 1'b0;
    check("midclaim_rdata", axi_rdata, 32'h3);
    step(1);
    rstn = 1'b0;
    #1;
    check("rst_mid_rvalid", {31'b0, axi_rvalid}, 32'h0);
    check("rst_mid_arready", {31'b0, axi_arready}, 32'h1);
    check("rst_mid_rdata", axi_rdata, 32'h0);
    check("rst_mid_meip", {31'b0, meip}, 32'h0);
    ext_src = '0;
    step(2);
    rstn = 1'b1;
    axi_rready = 1'b1;
    step(1);
    axi_read(32'h8, rd, rr);
    check("post_rst_pending", rd, 32'h0);
    axi_read(32'h4, rd, rr);
    check("post_rst_enable", rd, 32'h0);
    axi_read(32'hC, rd, rr);
    check("post_rst_claim", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Machine-mode interrupt aggregator directly downstream of the core-local timer block.
- Consumes that block's time_intr level and N_SRC external device interrupt lines (UART etc.).
- Drives mtip/msip/meip into the core's mip CSR.
- Exposes an AXI4-Lite slave with software-interrupt, enable, pending and claim/complete registers.

Parameters:
N_SRC, 8, number of external sources (1..31); source k has ID k+1, ID 0 means none.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
axi_araddr  input  32  read address
axi_arready  output  1  read address ready
axi_arvalid  input  1  read address valid
axi_arprot  input  3  ignored
axi_rdata  output  32  read data
axi_rready  input  1  read data ready
axi_rresp  output  2  read response
axi_rvalid  output  1  read data valid
axi_bready  input  1  write response ready
axi_bresp  output  2  write response
axi_bvalid  output  1  write response valid
axi_awaddr  input  32  write address
axi_awready  output  1  write address ready
axi_awvalid  input  1  write address valid
axi_awprot  input  3  ignored
axi_wdata  input  32  write data
axi_wready  output  1  write data ready
axi_wstrb  input  4  byte strobes; only byte 0 is significant
axi_wvalid  input  1  write data valid
time_intr  input  1  timer-compare level from the timer block
ext_src  input  N_SRC  external interrupt levels, asynchronous to clk
mtip  output  1  timer interrupt pending to core
msip  output  1  software interrupt pending to core
meip  output  1  external interrupt pending to core

Behaviour:
- Reset: all flops reset asynchronously on rstn low.
  - axi_arready/awready/wready=1; rvalid, bvalid, rdata, rresp, bresp=0.
  - mtip, msip, meip=0; MSIP=0; ENABLE=0; all sources IDLE; synchronizers cleared.
- Register map (word offsets; any other address gives SLVERR 2'b10, rdata 0, no side effect):
  - 0x0 MSIP: RW, bit0 only.
  - 0x4 ENABLE: RW, bits [N_SRC-1:0]; upper bits read 0.
  - 0x8 PENDING: RO, one bit per source in PENDING state, regardless of enable; writes ignored with OKAY.
  - 0xC CLAIM/COMPLETE: read = claim; write = complete.
- AXI read:
  - Accepted when arvalid && arready.
  - rvalid=1 with rdata/rresp on the next edge.
  - arready = ~rvalid, so no second read is accepted while a response is outstanding.
  - rvalid clears on rvalid && rready.
- AXI write:
  - Accepted only when awvalid && wvalid && awready in the same cycle.
  - bvalid=1 next edge; awready = wready = ~bvalid; bvalid clears on bvalid && bready.
  - Writes update a register only if wstrb[0]=1; always OKAY for mapped addresses.
- Source gateway:
  - ext_src passes through a 2-flop synchronizer, so 2 cycles before the gateway sees a change.
  - States: IDLE, PENDING, INSVC.
  - IDLE→PENDING when the synced level is 1.
  - PENDING holds even if the level drops.
  - PENDING→INSVC on claim.
  - INSVC→IDLE on complete. If the level is still 1, the source re-enters PENDING the following cycle.
- Claim:
  - Returns ID of the lowest-index source that is PENDING && ENABLE, else 0.
  - The returned source enters INSVC at the same edge rdata is registered.
  - Uses the pre-edge state vector. A source entering PENDING in the same cycle is not claimed.
- Complete:
  - wdata[4:0]=ID. If that source is INSVC it returns to IDLE; otherwise the write is ignored.
  - ID 0 or ID > N_SRC: ignored with OKAY.
  - A claim read and a complete write in the same cycle are both applied.
- Outputs (all registered, 1-cycle latency from the internal condition):
  - mtip = time_intr.
  - msip = MSIP[0].
  - meip = |(PENDING & ENABLE).
- Disabled sources still go PENDING but are neither claimable nor counted in meip. Enabling one later asserts meip the next cycle.

Optional Feature:
INTR_EDGE_EN
- Defined: gateways are edge-triggered.
  - A synced 0→1 transition moves IDLE→PENDING.
  - A rising edge seen during PENDING is absorbed.
  - A rising edge during INSVC sets a one-bit deferred flag. On complete, the source goes to PENDING instead of IDLE and the flag clears.
  - A steady high level never re-triggers.
- Undefined: level-triggered as above; no edge detector or deferred flag is built.

Decomposition:
- Shared package intr_pkg:
  - register offsets (MSIP_OFF, ENABLE_OFF, PENDING_OFF, CLAIM_OFF);
  - AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10);
  - gateway state encoding (IDLE/PENDING/INSVC).
- One sub-module, intr_gateway: synchronizer, per-source state machine and optional edge logic, instantiated N_SRC times.
- Top level holds AXI, registers and the priority encoder.

Test Plan:
- Reset then read 0x8 and 0xC → rdata 0, rresp OKAY; mtip/msip/meip=0.
- Write 0x1 to 0x0 → msip=1 one cycle after bvalid edge; write 0x0 → msip=0; read 0x0 → 0x1 between.
- ext_src=8'b0000_0110, ENABLE=0 → PENDING reads 0x6 and meip=0. Write ENABLE=0xFF → meip=1 next cycle. Claim → 2, then claim → 3, then claim → 0; meip=0.
- Source 1 held high, claim (→2), complete with ID 2 → PENDING bit1 set again within 2 cycles. Drop the source, claim, complete → PENDING 0. Completing ID 5 while idle → no change, bresp OKAY.
- time_intr toggled 0→1→0 → mtip follows with 1-cycle lag. Read address 0x10 → rresp 2'b10, rdata 0. rready held low → arready stays 0 until handshake.
- INTR_EDGE_EN: source 0 pulsed during INSVC → after complete(1), PENDING bit0=1. Source 0 held high without a new edge → no re-pend. Assert rstn low mid-claim response → rvalid=0 and all state IDLE immediately.
